multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32 control FSM with a retired-instruction counter.
// Define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of retiring them as NOPs.
module multicycle_controller #(
    parameter int CNT_W           = 32,
    parameter bit FETCH_ONLY_WAIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             branch,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_src,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BEQ, JAL, JALR, LUI, AUIPC
`ifdef MC_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_ALUR  = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t            state_q, state_d;
    logic              jalr_q, jalr_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              dmem_rdy;

    assign dmem_rdy = FETCH_ONLY_WAIT ? 1'b1 : mem_ready;
    assign instret  = instret_q;

    always_comb begin
        state_d = state_q;
        jalr_d  = 1'b0;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_ALUR:      state_d = EXECR;
                    OP_ALUI:      state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALR;
                    OP_LUI:       state_d = LUI;
                    OP_AUIPC:     state_d = AUIPC;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = dmem_rdy ? MEMWB : MEMREAD;
            MEMWRITE: state_d = dmem_rdy ? FETCH : MEMWRITE;
            MEMWB, ALUWB, BEQ: state_d = FETCH;
            EXECR, EXECI, LUI, AUIPC, JAL: state_d = ALUWB;
            JALR: begin
                jalr_d  = !jalr_q;
                state_d = jalr_q ? ALUWB : JALR;
            end
            default:  state_d = state_q;
        endcase
        retire    = !reset && (state_q != FETCH) && (state_d == FETCH);
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            jalr_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            jalr_q    <= jalr_d;
            instret_q <= instret_d;
        end
    end

    // Moore decode; only the FETCH strobes look at mem_ready directly
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE, AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            // first cycle parks rs1+imm in ALUOut, second behaves as JAL
            JALR: begin
                alu_src_a = jalr_q ? 2'b01 : 2'b10;
                alu_src_b = jalr_q ? 2'b10 : 2'b01;
                pc_write  = jalr_q;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            branch    = 1'b0;
        end
    end

    always_comb
        imm_src = (op == OP_LW || op == OP_ALUI || op == OP_JALR) ? 3'b000 :
                  (op == OP_SW)                                   ? 3'b001 :
                  (op == OP_BEQ)                                  ? 3'b010 :
                  (op == OP_JAL)                                  ? 3'b011 :
                  (op == OP_LUI || op == OP_AUIPC)                ? 3'b100 : 3'b000;

`ifdef MC_ILLEGAL_TRAP_EN
    assign trap = (state_q == TRAP);
`else
    assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed programs with a per-cycle expectation queue and a decoupled monitor.
module tb_multicycle_controller;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, mem_ready;
    logic [6:0]    op;
    logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, branch, retire, trap;
    logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]    imm_src;
    logic [CW-1:0] instret;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .branch(branch), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .retire(retire), .instret(instret), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0]   vec;
        logic [19:0]   mask;
        logic [CW-1:0] cnt;
        bit            cnt_chk;
        string         nm;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [6:0]    nxt_op = 7'b0;
    logic [19:0]   dut_vec;

    assign dut_vec = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, branch,
                      result_src, alu_src_a, alu_src_b, alu_op, imm_src, retire, trap};

    function automatic logic [19:0] pk(input logic mr, mw, as, irw, pcw, rw, br,
                                       input logic [1:0] rs, a, b, ao,
                                       input logic [2:0] im, input logic ret, tr);
        return {mr, mw, as, irw, pcw, rw, br, rs, a, b, ao, im, ret, tr};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [19:0] exp_vec(input string s, input logic rdy, input logic [6:0] o);
        logic [2:0] im = imm_of(o);
        case (s)
            "FETCH":    return pk(1, 0, 0, rdy, rdy, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 0, 0);
            "DECODE":   return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 0, 0);
            "NOPDEC":   return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 1, 0);
            "MEMADR":   return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0, 0);
            "MEMREAD":  return pk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0, 0);
            "MEMWB":    return pk(0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, im, 1, 0);
            "MEMWRITE": return pk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, rdy, 0);
            "EXECR":    return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, im, 0, 0);
            "EXECI":    return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, im, 0, 0);
            "LUI":      return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, im, 0, 0);
            "AUIPC":    return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 0, 0);
            "ALUWB":    return pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1, 0);
            "BEQ":      return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 2'b01, im, 1, 0);
            "JAL":      return pk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0, 0);
            "JALR1":    return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0, 0);
            "JALR2":    return pk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0, 0);
            "TRAP":     return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0, 1);
            default:    return 20'b0;
        endcase
    endfunction

    // drive one cycle and queue what the outputs must look like during it
    task automatic step(input string s, input logic rdy = 1'b1, input logic rst = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        op        = nxt_op;
        mem_ready = rdy;
        reset     = rst;
        e.nm      = s;
        e.vec     = exp_vec(s, rdy, nxt_op);
        e.mask    = rst ? pk(1, 1, 0, 1, 1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0) : '1;
        e.cnt     = exp_cnt;
        e.cnt_chk = !rst;
        q.push_back(e);
        if (rst) exp_cnt = '0;
        else if (e.vec[1]) exp_cnt = exp_cnt + 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ((dut_vec & e.mask) !== (e.vec & e.mask)) begin
                errors++;
                $display("FAIL %s ctl: got %05h want %05h (mask %05h)", e.nm, dut_vec, e.vec, e.mask);
            end
            if (e.cnt_chk) begin
                checks++;
                if (instret !== e.cnt) begin
                    errors++;
                    $display("FAIL %s instret: got %0d want %0d", e.nm, instret, e.cnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        op = 7'b0;
        step("RST", 0, 1);
        step("RST", 0, 1);
        nxt_op = 7'b0000011;
        repeat (3) step("FETCH", 0);
        step("FETCH"); step("DECODE"); step("MEMADR"); step("MEMREAD"); step("MEMWB");
        nxt_op = 7'b0100011;
        step("FETCH"); step("DECODE"); step("MEMADR");
        step("MEMWRITE", 0); step("MEMWRITE", 0); step("MEMWRITE", 1);
        nxt_op = 7'b0110011;
        step("FETCH"); step("DECODE"); step("EXECR"); step("ALUWB");
        nxt_op = 7'b0010011;
        step("FETCH"); step("DECODE"); step("EXECI"); step("ALUWB");
        nxt_op = 7'b1100011;
        step("FETCH"); step("DECODE"); step("BEQ");
        nxt_op = 7'b1101111;
        step("FETCH"); step("DECODE"); step("JAL"); step("ALUWB");
        nxt_op = 7'b1100111;
        step("FETCH"); step("DECODE"); step("JALR1"); step("JALR2"); step("ALUWB");
        nxt_op = 7'b0010111;
        step("FETCH"); step("DECODE"); step("AUIPC"); step("ALUWB");
        nxt_op = 7'b0000011;
        step("FETCH"); step("DECODE"); step("MEMADR");
        step("MEMREAD", 0); step("MEMREAD", 1); step("MEMWB");
        nxt_op = 7'b1111111;
`ifdef MC_ILLEGAL_TRAP_EN
        step("FETCH"); step("DECODE");
        repeat (10) step("TRAP", 0);
        step("RST", 0, 1);
`else
        step("FETCH"); step("NOPDEC");
`endif
        nxt_op = 7'b0100011;
        step("FETCH"); step("DECODE"); step("MEMADR"); step("MEMWRITE", 0);
        nxt_op = 7'b0110111;
        step("RST", 0, 1);
        for (int i = 0; i < 256; i++) begin
            step("FETCH"); step("DECODE"); step("LUI"); step("ALUWB");
        end
        step("FETCH", 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
